sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO for buffering data words between producer and consumer logic that share one clock domain. It generalises the team's FIFO with configurable data width and depth, a selectable read mode (registered or first-word fall-through), and programmable almost-full/almost-empty thresholds. It also provides an occupancy count, sticky overflow/underflow error flags and a synchronous flush. Storage is an internal register array; no SRAM macro is used.

---
 rtl/sync_fifo_param.sv | 133 +++++++++++++
 tb/tb_sync_fifo_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered or first-word fall-through
// read mode, programmable almost-full/almost-empty thresholds, occupancy
// count, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_param #(
    parameter int unsigned W_SIZE    = 32,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = (32'd1 << (WIDTH - 1)) - 32'd1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic              clk1,
    input  logic              rst1,
    input  logic              clr,
    input  logic              push,
    input  logic [W_SIZE-1:0] wdata,
    input  logic              pop,
    output logic [W_SIZE-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [WIDTH-1:0]  level,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned AW    = WIDTH - 1;
    localparam int unsigned DEPTH = 32'd1 << AW;

    logic [W_SIZE-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] wptr_q, wptr_d;
    logic [WIDTH-1:0] rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full_c, empty_c;
    logic             push_acc_c, pop_acc_c;
    logic [WIDTH-1:0] level_c;
    logic [AW-1:0]    waddr_c, raddr_c;

    // Status decode from the registered pointers; clr masks acceptance
    always_comb begin
        empty_c    = (wptr_q == rptr_q);
        full_c     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        level_c    = wptr_q - rptr_q;
        waddr_c    = wptr_q[AW-1:0];
        raddr_c    = rptr_q[AW-1:0];
        push_acc_c = push && !full_c && !clr;
        pop_acc_c  = pop && !empty_c && !clr;
    end

    // Next-state for pointers and sticky error flags
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else begin
            if (push_acc_c) wptr_d = wptr_q + WIDTH'(1);
            if (pop_acc_c)  rptr_d = rptr_q + WIDTH'(1);
            if (push && full_c) ovf_d = 1'b1;
            if (pop && empty_c) unf_d = 1'b1;
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Storage array; contents survive reset and flush
    always_ff @(posedge clk1) begin
        if (push_acc_c) mem_q[waddr_c] <= wdata;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [W_SIZE-1:0] rdata_q, rdata_d;
            logic              rvalid_q, rvalid_d;

            // Load the head word on an accepted pop, otherwise hold it
            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = pop_acc_c;
                if (pop_acc_c) rdata_d = mem_q[raddr_c];
            end

            // Registered read data and one-cycle valid strobe
            always_ff @(posedge clk1 or negedge rst1) begin
                if (!rst1) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end else begin : g_fwft_read
            // Head word is always presented; pop acknowledges it
            assign rdata  = mem_q[raddr_c];
            assign rvalid = !empty_c;
        end
    endgenerate

    assign full         = full_c;
    assign empty        = empty_c;
    assign level        = level_c;
    assign almost_full  = (32'(level_c) >= AFULL_TH);
    assign almost_empty = (32'(level_c) <= AEMPTY_TH);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int unsigned W         = 32;
    localparam int unsigned WIDTH     = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AFULL_TH  = 7;
    localparam int unsigned AEMPTY_TH = 1;

    logic             clk1, rst1, clr, push, pop;
    logic [W-1:0]     wdata;
    logic [W-1:0]     rdata0, rdata1;
    logic             rvalid0, rvalid1, full0, full1, empty0, empty1;
    logic             afull0, afull1, aempty0, aempty1;
    logic             ovf0, ovf1, unf0, unf1;
    logic [WIDTH-1:0] level0, level1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0] mq [$];
    logic         m_ovf, m_unf, m_rv;
    logic [W-1:0] m_rd;

    sync_fifo_param #(.W_SIZE(W), .WIDTH(WIDTH), .FWFT(0)) u_reg (
        .clk1(clk1), .rst1(rst1), .clr(clr), .push(push), .wdata(wdata), .pop(pop),
        .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
        .almost_full(afull0), .almost_empty(aempty0), .level(level0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.W_SIZE(W), .WIDTH(WIDTH), .FWFT(1)) u_fwft (
        .clk1(clk1), .rst1(rst1), .clr(clr), .push(push), .wdata(wdata), .pop(pop),
        .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
        .almost_full(afull1), .almost_empty(aempty1), .level(level1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = '0;
    endtask

    task automatic model_step(input logic p, input logic r, input logic c, input logic [W-1:0] d);
        bit was_full, was_empty;
        was_full  = (mq.size() == int'(DEPTH));
        was_empty = (mq.size() == 0);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            m_rv = 1'b0;
            if (p && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) begin
                m_rd = mq.pop_front();
                m_rv = 1'b1;
            end
            if (p && !was_full) mq.push_back(d);
        end
    endtask

    // One clock of stimulus; returns 1 ns after the edge with inputs idle
    task automatic step(input logic p, input logic r, input logic c, input logic [W-1:0] d);
        push  = p;
        pop   = r;
        clr   = c;
        wdata = d;
        @(posedge clk1);
        model_step(p, r, c, d);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        n_tests++; if (empty0 !== 1'b1 || aempty0 !== 1'b1) begin n_fail++; $display("FAIL reset_empty got empty=%b aempty=%b exp 1 1", empty0, aempty0); end
        n_tests++; if (level0 !== 4'd0 || full0 !== 1'b0 || afull0 !== 1'b0) begin n_fail++; $display("FAIL reset_level got level=%0d full=%b afull=%b exp 0 0 0", level0, full0, afull0); end
        n_tests++; if (rvalid0 !== 1'b0 || rdata0 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got rvalid=%b rdata=%h exp 0 0", rvalid0, rdata0); end
        n_tests++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got ovf=%b unf=%b exp 0 0", ovf0, unf0); end
        n_tests++; if (rvalid1 !== 1'b0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL reset_fwft got rvalid=%b empty=%b exp 0 1", rvalid1, empty1); end
        @(negedge clk1);
        rst1 = 1'b1;
        @(posedge clk1);
        #1;
        n_tests++; if (empty0 !== 1'b1 || level0 !== 4'd0 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL release_state got empty=%b level=%0d rvalid=%b exp 1 0 0", empty0, level0, rvalid0); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'(17 * (i + 1)));
            n_tests++; if (level0 !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level0, i + 1); end
            n_tests++; if (afull0 !== ((i + 1) >= 7)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, afull0, (i + 1) >= 7); end
        end
        step(1'b1, 1'b0, 1'b0, 32'h99);
        n_tests++; if (full0 !== 1'b1 || level0 !== 4'd8) begin n_fail++; $display("FAIL fill_full got full=%b level=%0d exp 1 8", full0, level0); end
        n_tests++; if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b/%b exp 1/1", ovf0, ovf1); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rdata1 !== 32'(17 * (i + 1)) || rvalid1 !== 1'b1) begin n_fail++; $display("FAIL drain_fwft[%0d] got %h v=%b exp %h v=1", i, rdata1, rvalid1, 32'(17 * (i + 1))); end
            step(1'b0, 1'b1, 1'b0, '0);
            n_tests++; if (rvalid0 !== 1'b1 || rdata0 !== 32'(17 * (i + 1))) begin n_fail++; $display("FAIL drain_rdata[%0d] got %h v=%b exp %h v=1", i, rdata0, rvalid0, 32'(17 * (i + 1))); end
            step(1'b0, 1'b0, 1'b0, '0);
            n_tests++; if (rvalid0 !== 1'b0 || rdata0 !== 32'(17 * (i + 1))) begin n_fail++; $display("FAIL drain_hold[%0d] got %h v=%b exp %h v=0", i, rdata0, rvalid0, 32'(17 * (i + 1))); end
        end
        step(1'b0, 1'b1, 1'b0, '0);
        n_tests++; if (unf0 !== 1'b1 || empty0 !== 1'b1 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL drain_underflow got unf=%b empty=%b rvalid=%b exp 1 1 0", unf0, empty0, rvalid0); end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, $urandom);
            n_tests++; if (level0 !== 4'd3) begin n_fail++; $display("FAIL wrap_level[%0d] got %0d exp 3", i, level0); end
            n_tests++; if (rvalid0 !== 1'b1 || rdata0 !== m_rd) begin n_fail++; $display("FAIL wrap_rdata[%0d] got %h exp %h", i, rdata0, m_rd); end
            n_tests++; if (rdata1 !== mq[0]) begin n_fail++; $display("FAIL wrap_fwft[%0d] got %h exp %h", i, rdata1, mq[0]); end
        end
        while (mq.size() < int'(DEPTH)) step(1'b1, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'b1, 1'b0, $urandom);
        n_tests++; if (level0 !== 4'd7 || ovf0 !== 1'b1 || full0 !== 1'b0) begin n_fail++; $display("FAIL full_pushpop got level=%0d ovf=%b full=%b exp 7 1 0", level0, ovf0, full0); end
        n_tests++; if (rdata0 !== m_rd) begin n_fail++; $display("FAIL full_pushpop_rdata got %h exp %h", rdata0, m_rd); end
        while (mq.size() > 0) begin
            step(1'b0, 1'b1, 1'b0, '0);
            n_tests++; if (rdata0 !== m_rd) begin n_fail++; $display("FAIL wrap_drain got %h exp %h", rdata0, m_rd); end
        end
        step(1'b1, 1'b1, 1'b0, 32'h5A5A_0001);
        n_tests++; if (level0 !== 4'd1 || unf0 !== 1'b1 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL empty_pushpop got level=%0d unf=%b rvalid=%b exp 1 1 0", level0, unf0, rvalid0); end
        n_tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h5A5A_0001) begin n_fail++; $display("FAIL empty_pushpop_fwft got v=%b %h exp 1 5a5a0001", rvalid1, rdata1); end
    endtask

    task automatic test_fwft();
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, 32'hA5);
        n_tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hA5) begin n_fail++; $display("FAIL fwft_show got v=%b %h exp 1 a5", rvalid1, rdata1); end
        n_tests++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL fwft_regmode_novalid got %b exp 0", rvalid0); end
        step(1'b0, 1'b0, 1'b0, '0);
        n_tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hA5) begin n_fail++; $display("FAIL fwft_hold got v=%b %h exp 1 a5", rvalid1, rdata1); end
        step(1'b0, 1'b1, 1'b0, '0);
        n_tests++; if (empty1 !== 1'b1 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL fwft_pop got empty=%b v=%b exp 1 0", empty1, rvalid1); end
        n_tests++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5) begin n_fail++; $display("FAIL fwft_regmode_pop got v=%b %h exp 1 a5", rvalid0, rdata0); end
    endtask

    task automatic test_flush_reset();
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
        n_tests++; if (level0 !== 4'd5 || ovf0 !== 1'b1) begin n_fail++; $display("FAIL flush_pre got level=%0d ovf=%b exp 5 1", level0, ovf0); end
        step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        n_tests++; if (level0 !== 4'd0 || ovf0 !== 1'b0 || empty0 !== 1'b1) begin n_fail++; $display("FAIL flush got level=%0d ovf=%b empty=%b exp 0 0 1", level0, ovf0, empty0); end
        n_tests++; if (level1 !== 4'd0 || rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL flush_rvalid got l1=%0d v1=%b v0=%b exp 0 0 0", level1, rvalid1, rvalid0); end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        n_tests++; if (level0 !== 4'd4) begin n_fail++; $display("FAIL refill got %0d exp 4", level0); end
        #2;
        rst1 = 1'b0;
        #1;
        model_reset();
        n_tests++; if (level0 !== 4'd0 || empty0 !== 1'b1 || aempty0 !== 1'b1 || afull0 !== 1'b0) begin n_fail++; $display("FAIL async_reset_status got level=%0d empty=%b ae=%b af=%b exp 0 1 1 0", level0, empty0, aempty0, afull0); end
        n_tests++; if (rvalid0 !== 1'b0 || rdata0 !== 32'd0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL async_reset_data got v=%b %h ovf=%b unf=%b exp 0 0 0 0", rvalid0, rdata0, ovf0, unf0); end
        n_tests++; if (level1 !== 4'd0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL async_reset_fwft got level=%0d v=%b exp 0 0", level1, rvalid1); end
        @(negedge clk1);
        rst1 = 1'b1;
    endtask

    task automatic test_random();
        logic [WIDTH+6:0] got, exp;
        int sz;
        bit p, r, c;
        for (int i = 0; i < 400; i++) begin
            if (((i / 50) % 2) == 0) begin
                p = ($urandom_range(99) < 75);
                r = ($urandom_range(99) < 30);
            end else begin
                p = ($urandom_range(99) < 30);
                r = ($urandom_range(99) < 75);
            end
            c = ($urandom_range(49) == 0);
            step(p, r, c, $urandom);
            sz  = mq.size();
            got = {level0, full0, empty0, afull0, aempty0, ovf0, unf0, rvalid0};
            exp = {WIDTH'(sz), sz == int'(DEPTH), sz == 0, sz >= int'(AFULL_TH), sz <= int'(AEMPTY_TH), m_ovf, m_unf, m_rv};
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rand_status_reg[%0d] got %h exp %h", i, got, exp); end
            n_tests++; if (rdata0 !== m_rd) begin n_fail++; $display("FAIL rand_rdata_reg[%0d] got %h exp %h", i, rdata0, m_rd); end
            got = {level1, full1, empty1, afull1, aempty1, ovf1, unf1, rvalid1};
            exp = {WIDTH'(sz), sz == int'(DEPTH), sz == 0, sz >= int'(AFULL_TH), sz <= int'(AEMPTY_TH), m_ovf, m_unf, sz != 0};
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rand_status_fwft[%0d] got %h exp %h", i, got, exp); end
            if (sz != 0) begin
                n_tests++; if (rdata1 !== mq[0]) begin n_fail++; $display("FAIL rand_rdata_fwft[%0d] got %h exp %h", i, rdata1, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_fwft();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
